instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder and control unit. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Each returned instruction word is held with its PC in an output register until decode accepts it with a valid/ready handshake. Redirects from branch, jal and jalr resolution flush any in-flight or buffered instruction and restart fetch at the new target.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 47 ++++
 rtl/instr_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Types and constants shared by the fetch, decode and control blocks.
//   Contents: fetch FSM state enum, NOP encoding, instruction size in bytes,
//   and the RV32I major opcodes used by decode/control.
//   No ports (package).
package riscv_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FULL  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Single-entry output register between fetch and decode. Holds one
//   instruction word and its PC with a valid/ready handshake; flush empties
//   it regardless of the handshake.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   load, load_instr,       write a new entry (only issued while empty)
//   load_pc
//   flush                   drop the entry (redirect)
//   instr_ready             decode accepts the entry this cycle
//   instr_valid,            entry to decode; instruction/instr_pc are held
//   instruction, instr_pc   until accepted
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [31:0]       load_instr,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              flush,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      instr_pc    <= RESET_PC;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr_valid <= 1'b1;
      instruction <= load_instr;
      instr_pc    <= load_pc;
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage: owns the PC, issues word reads to instruction memory over
//   req/ack, and hands each word with its PC to decode via fetch_buffer.
//   Redirects flush the buffered word and any in-flight read.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to add the sticky
//   fetch_misaligned output; without it, redirect_pc[1:0] is forced to 0.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_req, imem_addr              read request / word-aligned address
//   imem_ack, imem_rdata             one-cycle read response
//   instr_valid, instruction,        instruction to decode
//   instr_pc, instr_ready
//   redirect_valid, redirect_pc      branch/jal/jalr restart
//   fetch_misaligned                 (FETCH_MISALIGN_TRAP_EN only) sticky trap
//
// state | meaning
// FETCH | request addr_q outstanding (or held off by a misaligned trap)
// FULL  | word buffered for decode, no request
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              fetch_misaligned
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, target;
  logic              kill_q, kill_d, trap_q, trap_d;
  logic              bad_target, buf_load, buf_flush;

  // Without the trap, low address bits of a redirect are simply dropped.
  assign target     = TRAP_EN ? redirect_pc : (redirect_pc & ~ADDR_W'(3));
  assign bad_target = TRAP_EN && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC + STEP;
      addr_q  <= RESET_PC;
      kill_q  <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    kill_d    = kill_q;
    trap_d    = trap_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    if (redirect_valid && bad_target) begin
      trap_d    = 1'b1;
      buf_flush = 1'b1;
      state_d   = FETCH;
    end else if (!trap_q) begin
      unique case (state_q)
        FETCH: begin
          if (redirect_valid) begin
            pc_d = target;
            if (imem_ack) begin
              // Response lands with the redirect: drop it, restart at once.
              addr_d = target;
              kill_d = 1'b0;
            end else begin
              // Request address must stay stable until its ack; mark it dead.
              kill_d = 1'b1;
            end
          end else if (imem_ack) begin
            if (kill_q) begin
              kill_d = 1'b0;
              addr_d = pc_q;
            end else begin
              buf_load = 1'b1;
              // Next PC follows the word just returned (reset pc is already
              // one ahead of addr_q, so derive from addr_q, not pc_q).
              pc_d     = addr_q + STEP;
              state_d  = FULL;
            end
          end
        end
        FULL: begin
          if (redirect_valid) begin
            buf_flush = 1'b1;
            pc_d      = target;
            addr_d    = target;
            state_d   = FETCH;
          end else if (instr_ready) begin
            addr_d  = pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign imem_req  = (state_q == FETCH) && !trap_q;
  assign imem_addr = addr_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned = trap_q;
`endif

  fetch_buffer #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (buf_load),
    .load_instr  (imem_rdata),
    .load_pc     (addr_q),
    .flush       (buf_flush),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .instr_pc    (instr_pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory image: word at address a (0x0 holds 32'h00A00093).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00A0_0093 ^ (a << 5);
  endfunction

  // Stimulus knobs
  int          lat_min = 0, lat_max = 0, ready_pct = 100, redir_pct = 0;
  bit          trap_phase = 0, watchdog_en = 0;
  bit          force_en = 0, arm_addr_en = 0, arm_ack_en = 0;
  logic [31:0] force_target, arm_addr, arm_target, ack_target;

  // Memory model
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  // Reference model: the address decode must receive next, as a stream.
  logic [31:0] exp_pc = RESET_PC;
  bit          prev_valid, prev_ready, prev_redir;
  logic [31:0] prev_instr, prev_ipc;
  int          cyc = 0, idle = 0, n_acc = 0;
  int          valid_cyc[$];
  logic [31:0] valid_pc[$];
  logic [31:0] req_log[$];

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
    else                           t = {$urandom_range(0, 255), 2'b00};
`ifndef FETCH_MISALIGN_TRAP_EN
    if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
`endif
    return t;
  endfunction

  task automatic step();
    bit started;
    bit acc;
    started = 0;
    // Outputs reflect the previous edge; inputs of the previous cycle in prev_*.
    if (prev_redir) check_eq("valid_after_redirect", {31'b0, instr_valid}, 32'd0);
    else if (prev_valid && !prev_ready) begin
      check_eq("valid_hold", {31'b0, instr_valid}, 32'd1);
      check_eq("instr_hold", instruction, prev_instr);
      check_eq("pc_hold", instr_pc, prev_ipc);
    end
    if (instr_valid) begin
      check_eq("req_while_full", {31'b0, imem_req}, 32'd0);
      valid_cyc.push_back(cyc);
      valid_pc.push_back(instr_pc);
    end
    // Memory
    imem_ack = 1'b0;
    if (imem_req && !pend) begin
      started = 1;
      pend    = 1;
      paddr   = imem_addr;
      cnt     = $urandom_range(lat_max, lat_min);
      req_log.push_back(imem_addr);
      if (!trap_phase) check_eq("req_addr", imem_addr, exp_pc);
    end else if (pend && imem_req) begin
      check_eq("req_addr_stable", imem_addr, paddr);
    end
    if (pend) begin
      if (cnt == 0) begin
        imem_ack = 1'b1;
        pend     = 0;
      end else cnt--;
    end
    imem_rdata = imem_ack ? mem_word(paddr) : $urandom();
    // Decode side
    instr_ready    = ($urandom_range(0, 99) < ready_pct);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom();
    if (force_en) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_target;
      force_en       = 0;
    end else if (arm_addr_en && started && imem_addr == arm_addr) begin
      redirect_valid = 1'b1;
      redirect_pc    = arm_target;
      arm_addr_en    = 0;
    end else if (arm_ack_en && imem_ack) begin
      redirect_valid = 1'b1;
      redirect_pc    = ack_target;
      arm_ack_en     = 0;
    end else if (!trap_phase && $urandom_range(0, 99) < redir_pct) begin
      redirect_valid = 1'b1;
      redirect_pc    = rand_target();
    end
    // Model update for the coming edge: accept first, then redirect.
    acc = instr_valid && instr_ready;
    if (acc) begin
      check_eq("instr_pc", instr_pc, exp_pc);
      check_eq("instruction", instruction, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    if (instr_valid || redirect_valid) idle = 0;
    else idle++;
    if (watchdog_en && idle > 12) begin
      check_eq("progress_watchdog", 32'(idle), 32'd0);
      idle = 0;
    end
    prev_valid = instr_valid;
    prev_ready = instr_ready;
    prev_redir = redirect_valid;
    prev_instr = instruction;
    prev_ipc   = instr_pc;
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    pend           = 0;
    @(negedge clk);
    check_eq("rst_req", {31'b0, imem_req}, 32'd1);
    check_eq("rst_addr", imem_addr, RESET_PC);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_instr", instruction, 32'h0000_0013);
    check_eq("rst_pc", instr_pc, RESET_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);
`endif
    rst_n      = 1'b1;
    trap_phase = 0;
    exp_pc     = RESET_PC;
    prev_valid = 0;
    prev_ready = 0;
    prev_redir = 0;
    idle       = 0;
    cyc        = 0;
    valid_cyc.delete();
    valid_pc.delete();
    req_log.delete();
    step();
  endtask

  initial begin
    // 1: zero-wait memory, decode always ready
    lat_min = 0; lat_max = 0; ready_pct = 100; redir_pct = 0;
    do_reset();
    repeat (6) cycle();
    check_eq("t1_valid_count_ge3", {31'b0, valid_pc.size() >= 3}, 32'd1);
    if (valid_pc.size() >= 3) begin
      check_eq("t1_first_valid_cyc", 32'(valid_cyc[0]), 32'd1);
      check_eq("t1_second_valid_cyc", 32'(valid_cyc[1]), 32'd3);
      check_eq("t1_third_valid_cyc", 32'(valid_cyc[2]), 32'd5);
      check_eq("t1_pc0", valid_pc[0], 32'h0);
      check_eq("t1_pc1", valid_pc[1], 32'h4);
      check_eq("t1_pc2", valid_pc[2], 32'h8);
    end

    // 2: 3-cycle memory, decode stalls
    lat_min = 3; lat_max = 3; ready_pct = 0;
    do_reset();
    repeat (9) cycle();
    check_eq("t2_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("t2_instr", instruction, 32'h00A0_0093);
    check_eq("t2_single_request", 32'(req_log.size()), 32'd1);
    ready_pct = 100;
    repeat (3) cycle();
    check_eq("t2_next_req", req_log[req_log.size()-1], 32'h4);

    // 3: redirect while the request to 0x8 is outstanding
    lat_min = 2; lat_max = 2;
    arm_addr = 32'h8; arm_target = 32'h100; arm_addr_en = 1;
    do_reset();
    repeat (25) cycle();
    check_eq("t3_deliveries_ge3", {31'b0, valid_pc.size() >= 3}, 32'd1);
    if (valid_pc.size() >= 3) check_eq("t3_first_after_redirect", valid_pc[2], 32'h100);

    // 4: redirect in the same cycle as an ack
    lat_min = 1; lat_max = 1;
    ack_target = 32'h200; arm_ack_en = 1;
    do_reset();
    repeat (8) cycle();
    check_eq("t4_deliveries_ge1", {31'b0, valid_pc.size() >= 1}, 32'd1);
    if (valid_pc.size() >= 1) check_eq("t4_first_pc", valid_pc[0], 32'h200);
    if (req_log.size() >= 2) check_eq("t4_second_req", req_log[1], 32'h200);

    // 5: address wrap
    lat_min = 0; lat_max = 0;
    ack_target = 32'hFFFF_FFF8; arm_ack_en = 1;
    do_reset();
    repeat (10) cycle();
    check_eq("t5_reqs_ge4", {31'b0, req_log.size() >= 4}, 32'd1);
    if (req_log.size() >= 4) check_eq("t5_wrap_req", req_log[3], 32'h0);
    if (valid_pc.size() >= 3) check_eq("t5_wrap_pc", valid_pc[2], 32'h0);

    // 6: randomized traffic, with an asynchronous reset in the middle
    lat_min = 0; lat_max = 3; ready_pct = 70; redir_pct = 4;
    n_acc = 0;
    do_reset();
    watchdog_en = 1;
    repeat (1500) cycle();
    watchdog_en = 0;
    do_reset();
    watchdog_en = 1;
    repeat (1500) cycle();
    watchdog_en = 0;
    check_eq("rand_progress", {31'b0, n_acc > 300}, 32'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
    // 7: misaligned redirect traps until reset
    lat_min = 1; lat_max = 1; ready_pct = 100; redir_pct = 0;
    do_reset();
    repeat (5) cycle();
    force_target = 32'h102; force_en = 1;
    cycle();
    trap_phase = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_eq("t7_misaligned", {31'b0, fetch_misaligned}, 32'd1);
      check_eq("t7_req", {31'b0, imem_req}, 32'd0);
      check_eq("t7_valid", {31'b0, instr_valid}, 32'd0);
    end
    do_reset();
    repeat (4) cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
